// File: rtl/conv_sched_if.sv
// Handshake and operand/accumulator/output strobes between conv_sched and its neighbours.
// The master side drives start/out_ready, and the slave side is the scheduler.
interface conv_sched_if #(
  parameter int AW = 9,
  parameter int FW = 7
);
  logic          start;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [FW-1:0] flg;
  logic          load_en;
  logic [AW-1:0] img_row;
  logic [AW-1:0] img_col;
  logic [FW-1:0] ker_row;
  logic          acc_clr;
  logic          acc_en;
  logic          out_we;
  logic [AW-1:0] out_row;
  logic [AW-1:0] out_col;

  modport master (
    output start, out_ready,
    input  busy, done, flg, load_en, img_row, img_col, ker_row,
    input  acc_clr, acc_en, out_we, out_row, out_col
  );

  modport slave (
    input  start, out_ready,
    output busy, done, flg, load_en, img_row, img_col, ker_row,
    output acc_clr, acc_en, out_we, out_row, out_col
  );
endinterface

// File: rtl/conv_sched.sv
// Convolution sequencing controller: walks the output window across the padded image
// and drives the flg phase counter plus loader/accumulator/store strobes.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | flg=0, waiting for start
// S_RUN     | flg counts 0..3*N_K-1 for the current window
// S_WAIT_WR | result presented (out_we), stalled on out_ready, flg held
// S_DONE    | one-cycle done pulse after the last window is written
module conv_sched #(
  parameter int N_K = 3,
  parameter int IMG = 256,
  parameter int AW  = 9,
  parameter int FW  = 7
) (
  input  logic        clk,
  input  logic        rst,
  conv_sched_if.slave bus
);

  localparam logic [FW-1:0] FLG_LAST = FW'(3 * N_K - 1);
  localparam logic [FW-1:0] FLG_ACC  = FW'(2 * N_K);
  localparam logic [FW-1:0] FLG_LOAD = FW'(N_K);
  localparam logic [AW-1:0] WIN_LAST = AW'(IMG - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_WAIT_WR = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] flg_q, flg_d;
  logic [AW-1:0] win_row_q, win_row_d;
  logic [AW-1:0] win_col_q, win_col_d;
  logic          wr_done;

  always_comb begin
    state_d   = state_q;
    flg_d     = flg_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    wr_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          flg_d     = '0;
          win_row_d = '0;
          win_col_d = '0;
        end
      end
      S_RUN: begin
        if (flg_q == FLG_LAST) begin
          if (bus.out_ready) wr_done = 1'b1;
          else               state_d = S_WAIT_WR;
        end else begin
          flg_d = flg_q + FW'(1);
        end
      end
      S_WAIT_WR: begin
        if (bus.out_ready) wr_done = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A completed write either advances the window raster or ends the pass.
    if (wr_done) begin
      flg_d = '0;
      if (win_row_q == WIN_LAST && win_col_q == WIN_LAST) begin
        state_d   = S_DONE;
        win_row_d = '0;
        win_col_d = '0;
      end else begin
        state_d = S_RUN;
        if (win_col_q == WIN_LAST) begin
          win_col_d = '0;
          win_row_d = win_row_q + AW'(1);
        end else begin
          win_col_d = win_col_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      flg_q     <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      state_q   <= state_d;
      flg_q     <= flg_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end

  // Decodes come straight off flops, so reset reaches the outputs without a clock edge.
  assign bus.busy    = (state_q == S_RUN) || (state_q == S_WAIT_WR);
  assign bus.done    = (state_q == S_DONE);
  assign bus.flg     = flg_q;
  assign bus.load_en = (state_q == S_RUN) && (flg_q < FLG_LOAD);
  assign bus.img_row = win_row_q + AW'(flg_q);
  assign bus.img_col = win_col_q;
  assign bus.ker_row = flg_q;
  assign bus.acc_clr = (state_q == S_RUN) && (flg_q == '0);
  assign bus.acc_en  = (state_q == S_RUN) && (flg_q >= FLG_ACC);
  assign bus.out_we  = ((state_q == S_RUN) && (flg_q == FLG_LAST)) || (state_q == S_WAIT_WR);
  assign bus.out_row = win_row_q;
  assign bus.out_col = win_col_q;

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: window-index reference model compared every cycle,
// plus literal expectations for pass lengths, write order, backpressure and reset.
module tb_conv_sched;
  localparam int N_K  = 3;
  localparam int IMG  = 3;
  localparam int AW   = 4;
  localparam int FW   = 4;
  localparam int LAST = 3 * N_K - 1;
  localparam int NWIN = IMG * IMG;

  logic clk = 1'b0;
  logic rst = 1'b0;

  conv_sched_if #(.AW(AW), .FW(FW)) bus ();

  conv_sched #(.N_K(N_K), .IMG(IMG), .AW(AW), .FW(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 computing, 2 stalled on write, 3 done; w = raster window index.
  int mode = 0;
  int p    = 0;
  int w    = 0;

  int busy_cnt = 0;
  int done_cnt = 0;
  int we_cnt   = 0;
  int wr_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_advance();
    if (w == NWIN - 1) begin
      mode = 3; p = 0; w = 0;
    end else begin
      mode = 1; p = 0; w = w + 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = 0; p = 0; w = 0;
    end else begin
      case (mode)
        0: if (bus.start) begin mode = 1; p = 0; w = 0; end
        1: begin
          if (p == LAST) begin
            if (bus.out_ready) model_advance();
            else               mode = 2;
          end else begin
            p = p + 1;
          end
        end
        2: if (bus.out_ready) model_advance();
        default: mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    int ef;
    bit eld;
    ef  = (mode == 2) ? LAST : ((mode == 1) ? p : 0);
    eld = (mode == 1) && (p < N_K);
    chk("busy",    int'(bus.busy),    int'(mode == 1 || mode == 2));
    chk("done",    int'(bus.done),    int'(mode == 3));
    chk("flg",     int'(bus.flg),     ef);
    chk("load_en", int'(bus.load_en), int'(eld));
    chk("acc_clr", int'(bus.acc_clr), int'(mode == 1 && p == 0));
    chk("acc_en",  int'(bus.acc_en),  int'(mode == 1 && p >= 2 * N_K));
    chk("out_we",  int'(bus.out_we),  int'((mode == 1 && p == LAST) || mode == 2));
    chk("out_row", int'(bus.out_row), w / IMG);
    chk("out_col", int'(bus.out_col), w % IMG);
    chk("img_col", int'(bus.img_col), w % IMG);
    if (eld) begin
      chk("img_row", int'(bus.img_row), w / IMG + p);
      chk("ker_row", int'(bus.ker_row), p);
    end
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (bus.out_we) we_cnt++;
    if (bus.out_we && bus.out_ready) wr_q.push_back(int'(bus.out_row) * IMG + int'(bus.out_col));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    busy_cnt = 0;
    done_cnt = 0;
    we_cnt   = 0;
    wr_q.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.done) begin
      errors++;
      $display("FAIL wait_done timeout actual busy=%0d required done=1", bus.busy);
    end
  endtask

  task automatic wait_win(input int f, input int r, input int c, input int budget);
    int n;
    n = 0;
    while (!(bus.busy && int'(bus.flg) == f && int'(bus.out_row) == r && int'(bus.out_col) == c) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_win timeout actual flg=%0d row=%0d col=%0d required %0d/%0d/%0d",
               bus.flg, bus.out_row, bus.out_col, f, r, c);
    end
  endtask

  task automatic check_write_order(input string nm);
    chk({nm, "_nwrites"}, wr_q.size(), 9);
    for (int i = 0; i < wr_q.size() && i < NWIN; i++) chk({nm, "_wr_idx"}, wr_q[i], i);
  endtask

  task automatic check_all_reset(input string nm);
    chk({nm, "_busy"},    int'(bus.busy),    0);
    chk({nm, "_done"},    int'(bus.done),    0);
    chk({nm, "_flg"},     int'(bus.flg),     0);
    chk({nm, "_load_en"}, int'(bus.load_en), 0);
    chk({nm, "_acc_clr"}, int'(bus.acc_clr), 0);
    chk({nm, "_acc_en"},  int'(bus.acc_en),  0);
    chk({nm, "_out_we"},  int'(bus.out_we),  0);
    chk({nm, "_img_row"}, int'(bus.img_row), 0);
    chk({nm, "_img_col"}, int'(bus.img_col), 0);
    chk({nm, "_ker_row"}, int'(bus.ker_row), 0);
    chk({nm, "_out_row"}, int'(bus.out_row), 0);
    chk({nm, "_out_col"}, int'(bus.out_col), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) tick();
    check_all_reset("por");
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_busy", int'(bus.busy), 0);

    // Plain pass: 9 windows x 9 cycles, writes in raster order.
    clear_stats();
    pulse_start();
    chk("first_load_en", int'(bus.load_en), 1);
    chk("first_acc_clr", int'(bus.acc_clr), 1);
    chk("first_img_row", int'(bus.img_row), 0);
    wait_done(300);
    tick(); tick();
    chk("p1_busy_cycles", busy_cnt, 81);
    chk("p1_done_pulses", done_cnt, 1);
    chk("p1_we_cycles", we_cnt, 9);
    check_write_order("p1");

    // Backpressure: out_ready low for 3 cycles at the first out_we.
    clear_stats();
    bus.out_ready = 1'b0;
    pulse_start();
    begin
      int n;
      n = 0;
      while (!bus.out_we && n < 50) begin tick(); n++; end
    end
    chk("bp_first_we", int'(bus.out_we), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_we", int'(bus.out_we), 1);
      chk("bp_hold_flg", int'(bus.flg), 8);
      chk("bp_hold_row", int'(bus.out_row), 0);
      chk("bp_hold_col", int'(bus.out_col), 0);
    end
    bus.out_ready = 1'b1;
    wait_done(300);
    tick(); tick();
    chk("bp_busy_cycles", busy_cnt, 84);
    chk("bp_we_cycles", we_cnt, 12);
    check_write_order("bp");

    // Start pulsed mid-pass has no effect.
    clear_stats();
    pulse_start();
    wait_win(5, 0, 1, 100);
    pulse_start();
    wait_done(300);
    tick(); tick(); tick();
    chk("ign_busy_cycles", busy_cnt, 81);
    chk("ign_done_pulses", done_cnt, 1);

    // Randomised backpressure and stray start pulses.
    for (int r = 0; r < 3; r++) begin
      int n;
      clear_stats();
      pulse_start();
      n = 0;
      while (!bus.done && n < 2000) begin
        bus.out_ready = ($urandom_range(0, 2) != 0);
        bus.start     = ($urandom_range(0, 7) == 0);
        tick();
        n++;
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      chk("rnd_done_seen", int'(bus.done), 1);
      tick(); tick();
      check_write_order("rnd");
    end

    // Start held through DONE launches the next pass from the first idle cycle.
    clear_stats();
    bus.start = 1'b1;
    wait_done(300);
    tick();
    chk("b2b_idle_busy", int'(bus.busy), 0);
    tick();
    chk("b2b_restart_busy", int'(bus.busy), 1);
    chk("b2b_restart_flg", int'(bus.flg), 0);
    bus.start = 1'b0;
    wait_done(300);
    tick(); tick();
    chk("b2b_done_pulses", done_cnt, 2);
    chk("b2b_busy_cycles", busy_cnt, 162);

    // Asynchronous reset mid-window.
    clear_stats();
    pulse_start();
    wait_win(4, 0, 1, 100);
    #2 rst = 1'b1;
    #1 check_all_reset("async");
    tick(); tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_flg", int'(bus.flg), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
